// File: rtl/seq_divider8.sv
// Restoring unsigned divider: one quotient bit per cycle, start->done in WIDTH edges.
// Backpressure: start is ignored while busy; DONE accepts a new start back-to-back.
// Optional DIV_BY_ZERO_FLAG_EN: divisor 0 skips RUN and raises dbz with done.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic             dbz
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem_p;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             last_step;

  // dvd doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    shifted   = {rem_p, dvd[WIDTH-1]};
    diff      = shifted - {2'b00, dvs};
    q_bit     = ~diff[WIDTH+1];
    rem_nxt   = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    dvd_nxt   = {dvd[WIDTH-2:0], q_bit};
    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem_p     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd   <= dividend;
            dvs   <= divisor;
            rem_p <= '0;
            cnt   <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem_p <= rem_nxt;
          dvd   <= dvd_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            state     <= DONE;
            quotient  <= dvd_nxt;
            remainder <= rem_nxt[WIDTH-1:0];
`ifdef DIV_BY_ZERO_FLAG_EN
            dbz       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8; build with DIV_BY_ZERO_FLAG_EN to cover the dbz path.
module tb_seq_divider8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic       dbz;
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 8;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int edges;
  int busy_cnt;
  int pulses;

  seq_divider8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .dbz       (dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges after the accepting edge until done, bounded so a stuck DUT still ends.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    while (!done && n_edges < 40) begin
      if (busy) n_busy++;
      step();
      n_edges++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int lat, input int eq, input int er, input int edbz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_done(edges, busy_cnt);
    chk({tag, "_latency"}, edges, lat);
    chk({tag, "_busy_cycles"}, busy_cnt, lat);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_quotient"}, int'(quotient), eq);
    chk({tag, "_remainder"}, int'(remainder), er);
`ifdef DIV_BY_ZERO_FLAG_EN
    chk({tag, "_dbz"}, int'(dbz), edbz);
`else
    if (edbz > 1) chk({tag, "_dbz_unused"}, edbz, 0);
`endif
    step();
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_result_hold"}, int'(quotient), eq);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
`ifdef DIV_BY_ZERO_FLAG_EN
    chk("rst_dbz", int'(dbz), 0);
`endif
    rst_n = 1'b1;

    // First start right after reset release, accepted on the first edge.
    do_op("d100_7", 8'd100, 8'd7, 8, 14, 2, 0);
    do_op("d255_1", 8'd255, 8'd1, 8, 255, 0, 0);
    do_op("d5_9", 8'd5, 8'd9, 8, 0, 5, 0);

    // Back-to-back: new start presented in the DONE cycle.
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_done(edges, busy_cnt);
    chk("b2b_first_latency", edges, 8);
    chk("b2b_first_quotient", int'(quotient), 15);
    chk("b2b_first_remainder", int'(remainder), 5);
    dividend = 8'd50;
    divisor  = 8'd50;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_second_accepted", int'(busy), 1);
    chk("b2b_no_idle_done", int'(done), 0);
    step();
    chk("b2b_quotient_held_in_run", int'(quotient), 15);
    wait_done(edges, busy_cnt);
    chk("b2b_second_latency", edges + 1, 8);
    chk("b2b_second_quotient", int'(quotient), 1);
    chk("b2b_second_remainder", int'(remainder), 0);
    step();

    // start during RUN must be ignored.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_done(edges, busy_cnt);
    chk("ign_latency", edges + 3, 8);
    chk("ign_quotient", int'(quotient), 14);
    chk("ign_remainder", int'(remainder), 2);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    chk("ign_extra_done_pulses", pulses, 0);

    // Asynchronous reset in the 4th RUN cycle.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_quotient", int'(quotient), 0);
    chk("mid_rst_remainder", int'(remainder), 0);
    step();
    chk("mid_rst_stays_idle", int'(busy), 0);
    rst_n = 1'b1;
    do_op("d77_7", 8'd77, 8'd7, 8, 11, 0, 0);

    // Divide by zero.
    do_op("d42_0", 8'd42, 8'd0, ZERO_LAT, 255, 42, 1);
    // A following normal operation clears dbz.
    do_op("d9_3", 8'd9, 8'd3, 8, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
